// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, default frame geometry, counter sizing.
// Pure declarations, no logic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    function automatic int scnt_width(input int oversample);
        return (oversample > 2) ? $clog2(oversample) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_cond.sv
// Input conditioning: 2-flop rx synchronizer plus baud rising-edge tick generator.
// Latency: rx_s lags rx by 2 clk; tick pulses 1 clk wide, 2 clk after a baud rising edge.
// No backpressure: free-running, consumers must act on tick when it is present.
module uart_rx_cond (
    input  logic clk,
    input  logic reset,
    input  logic baud_clk,
    input  logic rx,
    output logic rx_s,
    output logic tick
);

    logic rx_q1;
    logic baud_q1;
    logic baud_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q1   <= 1'b1;
            rx_s    <= 1'b1;
            baud_q1 <= 1'b0;
            baud_q2 <= 1'b0;
        end else begin
            rx_q1   <= rx;
            rx_s    <= rx_q1;
            baud_q1 <= baud_clk;
            baud_q2 <= baud_q1;
        end
    end

    assign tick = baud_q1 & ~baud_q2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 deserialiser with ready/overrun/framing flags (UART_RX_PARITY_EN adds even parity).
// Latency: rx_ready rises 1 clk after the tick that samples the stop bit.
// Backpressure: none; an unacked byte is overwritten and rx_overrun is flagged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_baud_clk,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_frame_err
);

    localparam int SW = scnt_width(OVERSAMPLE);
    localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BCNT_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 tick;
    rx_state_t            state;
    logic [SW-1:0]        scnt;
    logic [2:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_rx_cond u_cond (
        .clk      (clk),
        .reset    (reset),
        .baud_clk (rx_baud_clk),
        .rx       (rx),
        .rx_s     (rx_s),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            scnt          <= '0;
            bcnt          <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_ready      <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            // Ack clears first; a delivery in the same cycle overrides below.
            if (rx_ack) begin
                rx_ready   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            scnt  <= '0;
                        end
                    end
                    START: begin
                        if (scnt == SCNT_MID) begin
                            scnt  <= '0;
                            bcnt  <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (scnt == SCNT_LAST) begin
                            scnt  <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bcnt == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (scnt == SCNT_LAST) begin
                            scnt    <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (scnt == SCNT_LAST) begin
                            scnt          <= '0;
                            rx_data       <= shreg;
                            rx_frame_err  <= ~rx_s;
                            rx_ready      <= 1'b1;
                            rx_overrun    <= ~rx_ack & (rx_ready | rx_overrun);
`ifdef UART_RX_PARITY_EN
                            rx_parity_err <= (^shreg) ^ par_bit;
`endif
                            // A low stop bit parks in BREAK so a held-low line cannot re-trigger.
                            state         <= rx_s ? IDLE : BREAK;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven aligned to rx_baud_clk rising edges, 16 ticks per bit.
module tb_uart_rx;

    localparam int BAUD_HALF = 30;            // rx_baud_clk toggles every 3 clk
    localparam int TICK_T    = 2 * BAUD_HALF;
    localparam int BIT_T     = 16 * TICK_T;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_TICK = 169;
`else
    localparam int STOP_TICK = 153;
`endif

    logic       clk;
    logic       reset;
    logic       rx_baud_clk;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overrun;
    logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx dut (
        .clk           (clk),
        .reset         (reset),
        .rx_baud_clk   (rx_baud_clk),
        .rx            (rx),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_overrun    (rx_overrun),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err (rx_parity_err),
`endif
        .rx_frame_err  (rx_frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rx_baud_clk = 1'b0;
        #2;
        forever #(BAUD_HALF) rx_baud_clk = ~rx_baud_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop_bit);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_T);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        #(BIT_T);
`else
        if (par) begin end
`endif
        rx = stop_bit;
        #(BIT_T);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge rx_baud_clk);
        send_bits(d, ^d, stop_bit);
    endtask

    task automatic do_ack();
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] d, input logic rdy,
                          input logic ovr, input logic ferr);
        @(negedge clk);
        chk({tag, ".data"},  32'(rx_data),      32'(d));
        chk({tag, ".ready"}, 32'(rx_ready),     32'(rdy));
        chk({tag, ".ovr"},   32'(rx_overrun),   32'(ovr));
        chk({tag, ".ferr"},  32'(rx_frame_err), 32'(ferr));
    endtask

    initial begin
        rx     = 1'b1;
        rx_ack = 1'b0;
        reset  = 1'b1;
        repeat (5) @(negedge clk);
        chk_rx("reset", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        chk("reset.perr", 32'(rx_parity_err), 32'd0);
`endif
        reset = 1'b0;
        #(BIT_T);

        send_frame(8'h55, 1'b1);
        chk_rx("b55", 8'h55, 1'b1, 1'b0, 1'b0);
        do_ack();
        chk("b55.ack_ready", 32'(rx_ready), 32'd0);

        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        chk_rx("ovr", 8'h3C, 1'b1, 1'b1, 1'b0);
        do_ack();
        chk("ovr.ack_ready", 32'(rx_ready), 32'd0);
        chk("ovr.ack_ovr",   32'(rx_overrun), 32'd0);

        // Stop bit low, line then held low: one delivery, no retrigger.
        send_frame(8'h00, 1'b0);
        #(3 * BIT_T);
        chk_rx("brk", 8'h00, 1'b1, 1'b0, 1'b1);
        rx = 1'b1;
        #(BIT_T);
        do_ack();
        send_frame(8'hFF, 1'b1);
        chk_rx("after_brk", 8'hFF, 1'b1, 1'b0, 1'b0);
        do_ack();

        // 4-tick low glitch: false start, nothing delivered.
        @(posedge rx_baud_clk);
        rx = 1'b0;
        #(4 * TICK_T);
        rx = 1'b1;
        #(2 * BIT_T);
        chk("glitch.ready", 32'(rx_ready), 32'd0);
        send_frame(8'h81, 1'b1);
        chk_rx("after_glitch", 8'h81, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 (0x81 still unacked).
        @(posedge rx_baud_clk);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            #(BIT_T);
        end
        rx = 1'b0;
        #(BIT_T / 2);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_rx("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        @(negedge clk) reset = 1'b0;
        #(3 * BIT_T);
        chk("midrst.ready", 32'(rx_ready), 32'd0);
        send_frame(8'h7E, 1'b1);
        chk_rx("b7e", 8'h7E, 1'b1, 1'b0, 1'b0);

        send_frame(8'h11, 1'b1);
        chk_rx("pre_coinc", 8'h11, 1'b1, 1'b1, 1'b0);

        // rx_ack held for exactly the clk in which the stop-bit tick is consumed.
        @(posedge rx_baud_clk);
        fork
            send_bits(8'hC3, ^8'hC3, 1'b1);
            begin
                #(TICK_T * STOP_TICK + 8);
                rx_ack = 1'b1;
                #10;
                rx_ack = 1'b0;
            end
        join
        chk_rx("coinc", 8'hC3, 1'b1, 1'b0, 1'b0);
        do_ack();
        chk("coinc.ack_ready", 32'(rx_ready), 32'd0);

`ifdef UART_RX_PARITY_EN
        @(posedge rx_baud_clk);
        send_bits(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        chk("par_ok.perr", 32'(rx_parity_err), 32'd0);
        chk("par_ok.data", 32'(rx_data), 32'h07);
        do_ack();
        @(posedge rx_baud_clk);
        send_bits(8'h07, 1'b0, 1'b1);
        @(negedge clk);
        chk("par_bad.perr", 32'(rx_parity_err), 32'd1);
        chk("par_bad.data", 32'(rx_data), 32'h07);
        do_ack();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
